// File: rtl/split_data.sv
// split_data: buffers signed 16-bit samples in a small circular FIFO and
// serializes each one as two bytes (MSB first) toward a UART transmitter.
//
// Output handshake: a byte is offered while valid_o=1 and is consumed on a
// rising edge where ready_i=1 as well. Once offered, data_o and valid_o stay
// stable until consumed. ready_i has no effect while valid_o=0.
//
// count_o counts only the samples waiting in the FIFO. The sample being
// serialized lives in the hold register and is not counted. data_o and
// valid_o are registers that take the value the FSM presents in its next
// state, so no input reaches an output without passing through a flop.
module split_data #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       count_o,
  output logic             overflow_o
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [2:0]       wr_ptr_q, wr_ptr_d;
  logic [2:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] head;
  logic             wr_en;
  logic             pop;

  assign head = fifo_mem[rd_ptr_q];

  // Write acceptance uses the occupancy at the start of the cycle, so a pop
  // in the same cycle never makes room for the incoming sample.
  always_comb begin
    wr_en      = valid_i && (count_q < DEPTH_C);
    overflow_d = overflow_q || (valid_i && (count_q == DEPTH_C));
  end

  // Serializer FSM: pops the FIFO head into the hold register and presents its high byte, then its low byte.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 4'd0) begin
          pop     = 1'b1;
          hold_d  = head;
          data_d  = head[15:8];
          valid_d = 1'b1;
          state_d = SEND_HI;
        end else begin
          data_d  = 8'h00;
          valid_d = 1'b0;
        end
      end
      SEND_HI: begin
        if (ready_i) begin
          data_d  = hold_q[7:0];
          valid_d = 1'b1;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (ready_i) begin
          if (count_q != 4'd0) begin
            // Chain straight into the next sample so no idle cycle appears.
            pop     = 1'b1;
            hold_d  = head;
            data_d  = head[15:8];
            valid_d = 1'b1;
            state_d = SEND_HI;
          end else begin
            data_d  = 8'h00;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        data_d  = 8'h00;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping. The 3-bit pointers wrap 7 to 0.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 3'd1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 3'd1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage. It needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= data_i;
    end
  end

  // State registers. Reset discards the pending byte and all queued samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      hold_q     <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_split_data.sv
// Testbench for split_data: directed scenarios plus a randomized run checked
// against a queue-based reference model of the sample/byte flow.
module tb_split_data;

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic        valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  count_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples waiting, the sample being sent, and which half.
  logic [15:0] m_fifo[$];
  logic [15:0] m_hold;
  logic        m_busy;
  logic        m_lo;
  logic        m_ovf;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [3:0]  m_count;

  split_data #(.WIDTH(16), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, and settle
  // 1ns after the edge so outputs can be sampled.
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic rs);
    logic accept;
    rst     = rs;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk);
    if (rs) begin
      m_fifo.delete();
      m_hold = 16'h0000;
      m_busy = 1'b0;
      m_lo   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      accept = v && (m_fifo.size() < 8);
      if (v && !accept) m_ovf = 1'b1;
      if (!m_busy) begin
        if (m_fifo.size() > 0) begin
          m_hold = m_fifo.pop_front();
          m_busy = 1'b1;
          m_lo   = 1'b0;
        end
      end else if (r) begin
        if (!m_lo) begin
          m_lo = 1'b1;
        end else if (m_fifo.size() > 0) begin
          m_hold = m_fifo.pop_front();
          m_lo   = 1'b0;
        end else begin
          m_busy = 1'b0;
        end
      end
      if (accept) m_fifo.push_back(d);
    end
    m_valid = m_busy;
    m_data  = !m_busy ? 8'h00 : (m_lo ? m_hold[7:0] : m_hold[15:8]);
    m_count = 4'(m_fifo.size());
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    n_checks++;
    if ({valid_o, data_o, count_o, overflow_o} !== {1'b0, 8'h00, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b, required 0 00 0 0",
               valid_o, data_o, count_o, overflow_o);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    logic [8:0] exp_v[4];
    exp_v[0] = {1'b0, 8'h00};
    exp_v[1] = {1'b1, 8'h80};
    exp_v[2] = {1'b1, 8'h01};
    exp_v[3] = {1'b0, 8'h00};
    step(1'b1, 16'h8001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0, 16'h0000, 1'b1, 1'b0);
      n_checks++;
      if ({valid_o, data_o} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL single_byte%0d: valid/data=%b/%h, required %b/%h",
                 i, valid_o, data_o, exp_v[i][8], exp_v[i][7:0]);
      end
    end
    n_checks++;
    if (count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL single_count: count=%0d, required 0", count_o);
    end
  endtask

  task automatic test_burst();
    logic [15:0] samples[3];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          first_cyc;
    int          last_cyc;
    samples[0] = 16'h1234;
    samples[1] = 16'hABCD;
    samples[2] = 16'h00FF;
    foreach (samples[k]) begin
      exp_q.push_back(samples[k][15:8]);
      exp_q.push_back(samples[k][7:0]);
    end
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) step(1'b1, samples[c], 1'b1, 1'b0);
      else       step(1'b0, 16'h0000, 1'b1, 1'b0);
      if (valid_o) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got_q.push_back(data_o);
      end
    end
    n_checks++;
    if (got_q !== exp_q) begin
      n_fail++;
      $display("FAIL burst_bytes: got %p, required %p", got_q, exp_q);
    end
    n_checks++;
    if ((last_cyc - first_cyc) != 5) begin
      n_fail++;
      $display("FAIL burst_gapless: span=%0d cycles, required 5", last_cyc - first_cyc);
    end
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_overflow: ovf=%b, required 0", overflow_o);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 16'h5A3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      n_checks++;
      if ({valid_o, data_o} !== {1'b1, 8'h5A}) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: valid/data=%b/%h, required 1/5a", i, valid_o, data_o);
      end
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++;
    if ({valid_o, data_o} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL backpressure_lo: valid/data=%b/%h, required 1/3c", valid_o, data_o);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_end: valid=%b, required 0", valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    n_checks++;
    if ({count_o, overflow_o, valid_o, data_o} !== {4'd8, 1'b1, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL overflow_fill: count=%0d ovf=%b valid=%b data=%h, required 8 1 1 00",
               count_o, overflow_o, valid_o, data_o);
    end
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(i));
    end
    for (int c = 0; c < 25; c++) begin
      if (valid_o) got_q.push_back(data_o);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    n_checks++;
    if (got_q !== exp_q) begin
      n_fail++;
      $display("FAIL overflow_drain: got %p, required %p", got_q, exp_q);
    end
    n_checks++;
    if ({overflow_o, count_o, valid_o} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%b count=%0d valid=%b, required 1 0 0",
               overflow_o, count_o, valid_o);
    end
  endtask

  task automatic test_full_pop();
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++;
    if ({count_o, overflow_o, data_o} !== {4'd8, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL fullpop_setup: count=%0d ovf=%b data=%h, required 8 0 00",
               count_o, overflow_o, data_o);
    end
    step(1'b1, 16'hDEAD, 1'b1, 1'b0);
    n_checks++;
    if ({count_o, overflow_o, valid_o, data_o} !== {4'd7, 1'b1, 1'b1, 8'h10}) begin
      n_fail++;
      $display("FAIL fullpop_drop: count=%0d ovf=%b valid=%b data=%h, required 7 1 1 10",
               count_o, overflow_o, valid_o, data_o);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_checks++;
    if ({count_o, valid_o, data_o} !== {4'd3, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL resetmid_setup: count=%0d valid=%b data=%h, required 3 1 00",
               count_o, valid_o, data_o);
    end
    step(1'b1, 16'h1111, 1'b1, 1'b1);
    n_checks++;
    if ({valid_o, count_o, overflow_o, data_o} !== {1'b0, 4'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL resetmid_after: valid=%b count=%0d ovf=%b data=%h, required 0 0 0 00",
               valid_o, count_o, overflow_o, data_o);
    end
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      if (valid_o) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL resetmid_stale: %0d cycles with valid_o=1, required 0", stale);
    end
  endtask

  task automatic test_random();
    int errs;
    logic v;
    logic r;
    logic rs;
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom_range(99) < 60);
      r  = ($urandom_range(99) < ((c / 500) % 2 == 0 ? 80 : 30));
      rs = ($urandom_range(999) < 3);
      step(v, 16'($urandom), r, rs);
      n_checks++;
      if ({valid_o, data_o, count_o, overflow_o} !== {m_valid, m_data, m_count, m_ovf}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: valid=%b data=%h count=%0d ovf=%b, required %b %h %0d %b",
                   c, valid_o, data_o, count_o, overflow_o, m_valid, m_data, m_count, m_ovf);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 16'h0000;
    ready_i = 1'b0;
    m_hold  = 16'h0000;
    m_busy  = 1'b0;
    m_lo    = 1'b0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_count = 4'd0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
